// File: rtl/stack_controller_pkg.sv
// Shared opcodes, FSM states and sp_block mux codes for the stack controller.
package stack_controller_pkg;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_PEEK  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_INIT_ARM,
    S_INIT_COMMIT,
    S_IDLE,
    S_SP_ARM,
    S_SP_COMMIT,
    S_MEM_WR,
    S_MEM_RD,
    S_RESP
  } state_e;

  localparam logic [2:0] SPSRC_HOLD = 3'b000;
  localparam logic [2:0] SPSRC_INC  = 3'b001;
  localparam logic [2:0] SPSRC_DEC  = 3'b010;

endpackage

// File: rtl/stack_depth_tracker.sv
// Entry counter for the stack: increment, decrement or clear, with full/empty flags.
module stack_depth_tracker #(
  parameter int unsigned MAX_DEPTH = 64,
  parameter int unsigned DEPTH_W   = 7
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               clr_i,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [DEPTH_W-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (clr_i)
      depth_d = '0;
    else if (inc_i && !full_o)
      depth_d = depth_q + DEPTH_W'(1);
    else if (dec_i && !empty_o)
      depth_d = depth_q - DEPTH_W'(1);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) depth_q <= '0;
    else         depth_q <= depth_d;
  end

  assign depth_o = depth_q;
  assign full_o  = (depth_q == DEPTH_W'(MAX_DEPTH));
  assign empty_o = (depth_q == '0);

endmodule

// File: rtl/stack_controller.sv
// Stack-op sequencer: drives sp_block two-phase SP updates and the data-memory port.
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = 64,
  parameter int unsigned DEPTH_W   = 7
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               cmdValid,
  output logic               cmdReady,
  input  logic [1:0]         cmdOp,
  input  logic [15:0]        cmdData,
  output logic               rspValid,
  input  logic               rspReady,
  output logic [15:0]        rspData,
  output logic               rspErr,
  output logic [2:0]         spSrc,
  output logic               spWrite,
  output logic               spReset,
  input  logic [15:0]        spCur,
  output logic               memReq,
  output logic               memWe,
  output logic [15:0]        memAddr,
  output logic [15:0]        memWData,
  input  logic [15:0]        memRData,
  input  logic               memAck,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] data_q, data_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        inc, dec, clr;

  stack_depth_tracker #(
    .MAX_DEPTH(MAX_DEPTH),
    .DEPTH_W  (DEPTH_W)
  ) u_depth (
    .clock  (clock),
    .resetN (resetN),
    .inc_i  (inc),
    .dec_i  (dec),
    .clr_i  (clr),
    .depth_o(depth),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cmdReady   = 1'b0;
    rspValid   = 1'b0;
    spSrc      = SPSRC_HOLD;
    spWrite    = 1'b0;
    spReset    = 1'b0;
    memReq     = 1'b0;
    memWe      = 1'b0;
    memAddr    = '0;
    inc        = 1'b0;
    dec        = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      S_INIT_ARM: begin
        spReset = 1'b1;
        state_d = S_INIT_COMMIT;
      end
      S_INIT_COMMIT: begin
        spReset = 1'b1;
        spWrite = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          op_d       = op_e'(cmdOp);
          data_d     = cmdData;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          // Full/empty are judged on the depth seen at accept.
          unique case (op_e'(cmdOp))
            OP_PUSH:  if (full) begin rsp_err_d = 1'b1; state_d = S_RESP; end
                      else state_d = S_SP_ARM;
            OP_POP,
            OP_PEEK:  if (empty) begin rsp_err_d = 1'b1; state_d = S_RESP; end
                      else state_d = S_MEM_RD;
            OP_CLEAR: state_d = S_SP_ARM;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_SP_ARM, S_SP_COMMIT: begin
        spSrc   = (op_q == OP_PUSH) ? SPSRC_DEC :
                  (op_q == OP_POP)  ? SPSRC_INC : SPSRC_HOLD;
        spReset = (op_q == OP_CLEAR);
        if (state_q == S_SP_ARM) begin
          state_d = S_SP_COMMIT;
        end else begin
          spWrite = 1'b1;
          inc     = (op_q == OP_PUSH);
          dec     = (op_q == OP_POP);
          clr     = (op_q == OP_CLEAR);
          state_d = (op_q == OP_PUSH) ? S_MEM_WR : S_RESP;
        end
      end
      S_MEM_WR: begin
        memReq  = 1'b1;
        memWe   = 1'b1;
        memAddr = spCur;
        if (memAck) state_d = S_RESP;
      end
      S_MEM_RD: begin
        memReq  = 1'b1;
        memAddr = spCur;
        if (memAck) begin
          rsp_data_d = memRData;
          state_d    = (op_q == OP_POP) ? S_SP_ARM : S_RESP;
        end
      end
      S_RESP: begin
        rspValid = 1'b1;
        if (rspReady) state_d = S_IDLE;
      end
      default: state_d = S_INIT_ARM;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_INIT_ARM;
      op_q       <= OP_PUSH;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign memWData = data_q;
  assign rspData  = rsp_data_q;
  assign rspErr   = rsp_err_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: models sp_block and a word memory with programmable ack delay.
module tb_stack_controller;
  localparam int MAXD = 64;

  logic        clock = 1'b0, resetN = 1'b0;
  logic        cmdValid = 1'b0, cmdReady, rspValid, rspReady = 1'b0, rspErr;
  logic [1:0]  cmdOp = 2'b00;
  logic [15:0] cmdData = '0, rspData, spCur, memAddr, memWData, memRData;
  logic [2:0]  spSrc;
  logic        spWrite, spReset, memReq, memWe, memAck, full, empty;
  logic [6:0]  depth;

  always #5 clock = ~clock;

  stack_controller #(.MAX_DEPTH(MAXD), .DEPTH_W(7)) dut (
    .clock(clock), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdData(cmdData), .rspValid(rspValid), .rspReady(rspReady),
    .rspData(rspData), .rspErr(rspErr), .spSrc(spSrc), .spWrite(spWrite),
    .spReset(spReset), .spCur(spCur), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWData(memWData), .memRData(memRData), .memAck(memAck),
    .depth(depth), .full(full), .empty(empty)
  );

  int tests = 0, fails = 0;
  int ack_cycle = 1, ack_cnt = 0, memreq_cycles = 0;
  logic [15:0] mem [0:32767];
  logic [15:0] last_waddr = '0, last_wdata = '0;
  logic [15:0] sp_q = 16'hA5A4;
  logic [15:0] mq[$];

  // sp_block model (no reset of its own) and memory model
  assign spCur    = sp_q;
  assign memAck   = memReq && (ack_cnt == ack_cycle - 1);
  assign memRData = mem[memAddr[15:1]];

  always @(posedge clock) begin
    if (spWrite) begin
      if (spReset)              sp_q <= 16'h0000;
      else if (spSrc == 3'b001) sp_q <= sp_q + 16'd2;
      else if (spSrc == 3'b010) sp_q <= sp_q - 16'd2;
    end
    if (memReq) begin
      memreq_cycles <= memreq_cycles + 1;
      if (memAck) begin
        ack_cnt <= 0;
        if (memWe) begin
          mem[memAddr[15:1]] <= memWData;
          last_waddr <= memAddr;
          last_wdata <= memWData;
        end
      end else ack_cnt <= ack_cnt + 1;
    end else ack_cnt <= 0;
  end

  function automatic logic [15:0] exp_sp();
    return 16'(0) - 16'(2 * mq.size());
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, input int rdy_delay,
                        output logic [15:0] rd, output logic err, output int lat,
                        output bit hold_ok);
    int n = 0;
    hold_ok = 1'b1;
    rd = '0; err = 1'b0; lat = 0;
    while (!cmdReady && n < 200) begin @(posedge clock); #1; n++; end
    if (!cmdReady) begin
      $display("FAIL cmd_ready_timeout: cmdReady=%b required 1", cmdReady);
      fails++; tests++;
      return;
    end
    cmdValid = 1'b1; cmdOp = op; cmdData = d;
    @(posedge clock); #1;
    cmdValid = 1'b0;
    lat = 1;
    while (!rspValid && lat < 200) begin @(posedge clock); #1; lat++; end
    if (!rspValid) begin
      $display("FAIL rsp_timeout: rspValid=%b required 1", rspValid);
      fails++; tests++;
      return;
    end
    rd = rspData; err = rspErr;
    for (int i = 0; i < rdy_delay; i++) begin
      @(posedge clock); #1;
      if (!rspValid || rspData !== rd) hold_ok = 1'b0;
    end
    rspReady = 1'b1;
    @(posedge clock); #1;
    rspReady = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({cmdReady, rspValid, rspErr, memReq, memWe, spWrite, spReset, spSrc} !== 10'b0000001000 ||
        rspData !== 16'h0 || memAddr !== 16'h0 || memWData !== 16'h0 || depth !== 7'd0) begin
      $display("FAIL reset_values: ctl=%b rspData=%h memAddr=%h memWData=%h depth=%0d",
               {cmdReady, rspValid, rspErr, memReq, memWe, spWrite, spReset, spSrc},
               rspData, memAddr, memWData, depth);
      fails++;
    end
    resetN = 1'b1;
    tests++;
    if (spReset !== 1'b1 || spWrite !== 1'b0 || cmdReady !== 1'b0) begin
      $display("FAIL init_cycle1: spReset=%b spWrite=%b cmdReady=%b required 1 0 0", spReset, spWrite, cmdReady);
      fails++;
    end
    @(posedge clock); #1;
    tests++;
    if (spReset !== 1'b1 || spWrite !== 1'b1 || cmdReady !== 1'b0) begin
      $display("FAIL init_cycle2: spReset=%b spWrite=%b cmdReady=%b required 1 1 0", spReset, spWrite, cmdReady);
      fails++;
    end
    @(posedge clock); #1;
    tests++;
    if (cmdReady !== 1'b1 || spCur !== 16'h0 || empty !== 1'b1 || full !== 1'b0) begin
      $display("FAIL init_done: cmdReady=%b spCur=%h empty=%b full=%b required 1 0000 1 0", cmdReady, spCur, empty, full);
      fails++;
    end
    mq.delete();
  endtask

  task automatic test_push_pair();
    logic [15:0] rd, vals [2], addrs [2];
    logic err; int lat; bit hok;
    vals[0] = 16'hBEEF; vals[1] = 16'h1234;
    addrs[0] = 16'hFFFE; addrs[1] = 16'hFFFC;
    for (int i = 0; i < 2; i++) begin
      do_cmd(2'b00, vals[i], 0, rd, err, lat, hok);
      mq.push_back(vals[i]);
      tests++;
      if (err !== 1'b0 || rd !== 16'h0 || lat != 4 || last_waddr !== addrs[i] || last_wdata !== vals[i]) begin
        $display("FAIL push%0d: err=%b rd=%h lat=%0d waddr=%h wdata=%h required 0 0000 4 %h %h",
                 i, err, rd, lat, last_waddr, last_wdata, addrs[i], vals[i]);
        fails++;
      end
    end
    tests++;
    if (spCur !== 16'hFFFC || depth !== 7'd2) begin
      $display("FAIL push_pair_state: spCur=%h depth=%0d required fffc 2", spCur, depth);
      fails++;
    end
  endtask

  task automatic test_pop();
    logic [15:0] rd, expd; logic err; int lat, snap; bit hok;
    for (int i = 0; i < 2; i++) begin
      expd = mq.pop_back();
      do_cmd(2'b01, 16'h0, 0, rd, err, lat, hok);
      tests++;
      if (err !== 1'b0 || rd !== expd || lat != 4) begin
        $display("FAIL pop%0d: err=%b rd=%h lat=%0d required 0 %h 4", i, err, rd, lat, expd);
        fails++;
      end
    end
    tests++;
    if (spCur !== 16'h0 || empty !== 1'b1 || depth !== 7'd0) begin
      $display("FAIL pop_empty_state: spCur=%h empty=%b depth=%0d required 0000 1 0", spCur, empty, depth);
      fails++;
    end
    snap = memreq_cycles;
    do_cmd(2'b01, 16'h0, 0, rd, err, lat, hok);
    tests++;
    if (err !== 1'b1 || rd !== 16'h0 || lat != 1 || spCur !== 16'h0 || memreq_cycles != snap) begin
      $display("FAIL underflow: err=%b rd=%h lat=%0d spCur=%h memreq=%0d required 1 0000 1 0000 0",
               err, rd, lat, spCur, memreq_cycles - snap);
      fails++;
    end
  endtask

  task automatic test_fill();
    logic [15:0] rd, d; logic err; int lat, snap; bit hok;
    for (int i = 0; i < MAXD; i++) begin
      d = 16'($urandom);
      ack_cycle = $urandom_range(1, 3);
      do_cmd(2'b00, d, 0, rd, err, lat, hok);
      mq.push_back(d);
      tests++;
      if (err !== 1'b0 || last_wdata !== d || last_waddr !== exp_sp()) begin
        $display("FAIL fill%0d: err=%b wdata=%h waddr=%h required 0 %h %h", i, err, last_wdata, last_waddr, d, exp_sp());
        fails++;
      end
    end
    ack_cycle = 1;
    tests++;
    if (full !== 1'b1 || depth !== 7'(MAXD) || spCur !== 16'hFF80) begin
      $display("FAIL full_state: full=%b depth=%0d spCur=%h required 1 %0d ff80", full, depth, spCur, MAXD);
      fails++;
    end
    snap = memreq_cycles;
    do_cmd(2'b00, 16'hDEAD, 0, rd, err, lat, hok);
    tests++;
    if (err !== 1'b1 || rd !== 16'h0 || lat != 1 || memreq_cycles != snap || spCur !== 16'hFF80 || depth !== 7'(MAXD)) begin
      $display("FAIL overflow: err=%b rd=%h lat=%0d memreq=%0d spCur=%h depth=%0d required 1 0000 1 0 ff80 %0d",
               err, rd, lat, memreq_cycles - snap, spCur, depth, MAXD);
      fails++;
    end
  endtask

  task automatic test_peek_stall();
    logic [15:0] rd, sp0; logic err; int lat, snap; bit hok;
    ack_cycle = 3;
    snap = memreq_cycles;
    sp0 = spCur;
    do_cmd(2'b10, 16'h0, 2, rd, err, lat, hok);
    ack_cycle = 1;
    tests++;
    if (err !== 1'b0 || rd !== mq[$] || lat != 4 || memreq_cycles - snap != 3 || !hok || spCur !== sp0) begin
      $display("FAIL peek_stall: err=%b rd=%h lat=%0d memreq=%0d hold=%b spCur=%h required 0 %h 4 3 1 %h",
               err, rd, lat, memreq_cycles - snap, hok, spCur, mq[$], sp0);
      fails++;
    end
  endtask

  task automatic test_clear();
    logic [15:0] rd; logic err; int lat; bit hok;
    do_cmd(2'b11, 16'h0, 0, rd, err, lat, hok);
    mq.delete();
    tests++;
    if (err !== 1'b0 || rd !== 16'h0 || lat != 3 || spCur !== 16'h0 || depth !== 7'd0 || empty !== 1'b1) begin
      $display("FAIL clear: err=%b rd=%h lat=%0d spCur=%h depth=%0d empty=%b required 0 0000 3 0000 0 1",
               err, rd, lat, spCur, depth, empty);
      fails++;
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, d, exp_rd; logic err, exp_err; logic [1:0] op; int lat, r; bit hok;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      op = (r < 9) ? 2'b00 : (r < 14) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      d = 16'($urandom);
      ack_cycle = $urandom_range(1, 3);
      exp_rd = '0; exp_err = 1'b0;
      case (op)
        2'b00: if (mq.size() == MAXD) exp_err = 1'b1; else mq.push_back(d);
        2'b01: if (mq.size() == 0) exp_err = 1'b1; else exp_rd = mq.pop_back();
        2'b10: if (mq.size() == 0) exp_err = 1'b1; else exp_rd = mq[$];
        default: mq.delete();
      endcase
      do_cmd(op, d, $urandom_range(0, 2), rd, err, lat, hok);
      tests++;
      if (err !== exp_err || rd !== exp_rd || !hok || depth !== 7'(mq.size()) || spCur !== exp_sp() ||
          empty !== (mq.size() == 0) || full !== (mq.size() == MAXD)) begin
        $display("FAIL random%0d op=%0d: err=%b rd=%h hold=%b depth=%0d spCur=%h required %b %h 1 %0d %h",
                 i, op, err, rd, hok, depth, spCur, exp_err, exp_rd, mq.size(), exp_sp());
        fails++;
      end
    end
    ack_cycle = 1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    ack_cycle = 20;
    while (!cmdReady && n < 200) begin @(posedge clock); #1; n++; end
    cmdValid = 1'b1; cmdOp = 2'b00; cmdData = 16'hCAFE;
    @(posedge clock); #1;
    cmdValid = 1'b0;
    n = 0;
    while (!(memReq && memWe) && n < 50) begin @(posedge clock); #1; n++; end
    tests++;
    if (!(memReq && memWe)) begin
      $display("FAIL midreset_reach_wr: memReq=%b memWe=%b required 1 1", memReq, memWe);
      fails++;
    end
    #2 resetN = 1'b0;
    #1;
    tests++;
    if (memReq !== 1'b0 || spReset !== 1'b1 || depth !== 7'd0) begin
      $display("FAIL midreset_drop: memReq=%b spReset=%b depth=%0d required 0 1 0", memReq, spReset, depth);
      fails++;
    end
    @(posedge clock); #1;
    resetN = 1'b1;
    ack_cycle = 1;
    repeat (2) @(posedge clock);
    #1;
    mq.delete();
    tests++;
    if (cmdReady !== 1'b1 || depth !== 7'd0 || spCur !== 16'h0 || empty !== 1'b1) begin
      $display("FAIL midreset_after_init: cmdReady=%b depth=%0d spCur=%h empty=%b required 1 0 0000 1",
               cmdReady, depth, spCur, empty);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_push_pair();
    test_pop();
    test_fill();
    test_peek_stall();
    test_clear();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
